// File: rtl/free_list_banked_pkg.sv
// free_list_banked_pkg
// Shared sizing constants and types for the banked physical-register free list.
// Contents:
//   - register-file and bank geometry (PR count, bank count, per-bank depth)
//   - stall hysteresis thresholds
//   - pr_t        : full physical register number
//   - pr_entry_t  : per-bank storage entry (PR number without the bank bits)
//   - ptr_t / count_t : per-bank FIFO pointer and occupancy
//   - init_entry(): stored entry at FIFO slot i after reset
package free_list_banked_pkg;

  localparam int PR_COUNT                      = 128;
  localparam int LOG_PR_COUNT                  = $clog2(PR_COUNT);
  localparam int AR_COUNT                      = 32;
  localparam int FREE_LIST_BANK_COUNT          = 4;
  localparam int LOG_FREE_LIST_BANK_COUNT      = $clog2(FREE_LIST_BANK_COUNT);
  localparam int FREE_LIST_LENGTH_PER_BANK     = PR_COUNT / FREE_LIST_BANK_COUNT;
  localparam int LOG_FREE_LIST_LENGTH_PER_BANK = $clog2(FREE_LIST_LENGTH_PER_BANK);
  localparam int FREE_LIST_LOWER_THRESHOLD     = 8;
  localparam int FREE_LIST_UPPER_THRESHOLD     = 24;

  // PRs 0..AR_COUNT-1 hold the architectural mapping at reset; the rest are
  // spread evenly over the banks by their low bits.
  localparam int INIT_COUNT_PER_BANK = (PR_COUNT - AR_COUNT) / FREE_LIST_BANK_COUNT;
  localparam int INIT_ENTRY_BASE     = AR_COUNT / FREE_LIST_BANK_COUNT;

  typedef logic [LOG_PR_COUNT-1:0]                          pr_t;
  typedef logic [LOG_PR_COUNT-LOG_FREE_LIST_BANK_COUNT-1:0] pr_entry_t;
  typedef logic [LOG_FREE_LIST_BANK_COUNT-1:0]              bank_idx_t;
  typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK-1:0]         ptr_t;
  typedef logic [LOG_FREE_LIST_LENGTH_PER_BANK:0]           count_t;

  // Slot i of every bank holds PR AR_COUNT + BANKS*i + bank, i.e. upper bits
  // INIT_ENTRY_BASE + i regardless of the bank index.
  function automatic pr_entry_t init_entry(input int i);
    return pr_entry_t'(INIT_ENTRY_BASE + i);
  endfunction

endpackage

// File: rtl/free_list_banked_if.sv
// free_list_banked_if
// Commit/rename side bundle of the banked free list.
//   dealloc_valid_by_bank [BANKS]        freed-PR strobe per bank (commit -> list)
//   dealloc_PR_by_bank    [BANKS][PR]    freed PR per bank
//   alloc_ready_by_bank   [BANKS]        rename consumes the presented PR
//   alloc_valid_by_bank   [BANKS]        bank presents a free PR
//   alloc_PR_by_bank      [BANKS][PR]    PR at the bank head
//   free_count_by_bank    [BANKS][CNT]   occupancy per bank
//   free_list_stall                      rename back-off request
// Modports: master = commit/rename side, slave = free list.
interface free_list_banked_if;
  import free_list_banked_pkg::*;

  logic [FREE_LIST_BANK_COUNT-1:0]                     dealloc_valid_by_bank;
  logic [FREE_LIST_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]   dealloc_PR_by_bank;
  logic [FREE_LIST_BANK_COUNT-1:0]                     alloc_ready_by_bank;
  logic [FREE_LIST_BANK_COUNT-1:0]                     alloc_valid_by_bank;
  logic [FREE_LIST_BANK_COUNT-1:0][LOG_PR_COUNT-1:0]   alloc_PR_by_bank;
  logic [FREE_LIST_BANK_COUNT-1:0][LOG_FREE_LIST_LENGTH_PER_BANK:0] free_count_by_bank;
  logic                                                free_list_stall;

  modport master (
    output dealloc_valid_by_bank, dealloc_PR_by_bank, alloc_ready_by_bank,
    input  alloc_valid_by_bank, alloc_PR_by_bank, free_count_by_bank, free_list_stall
  );

  modport slave (
    input  dealloc_valid_by_bank, dealloc_PR_by_bank, alloc_ready_by_bank,
    output alloc_valid_by_bank, alloc_PR_by_bank, free_count_by_bank, free_list_stall
  );
endinterface

// File: rtl/free_list_bank.sv
// free_list_bank
// One bank of the free list: a circular FIFO of PR upper bits, loaded with its
// share of the unmapped PRs on reset.
//   CLK, RST     clock; asynchronous active-high reset
//   push_valid   freed PR strobe;   push_pr   freed PR (low bits must equal BANK_IDX)
//   pop_ready    consumer takes the presented PR
//   alloc_valid  a PR is presented; alloc_pr  presented PR
//   count        registered occupancy; count_next  occupancy after this edge
// Optional: FREE_LIST_BYPASS_EN lets an empty bank present an incoming freed PR
// in the same cycle (and a same-cycle take cancels the write).
module free_list_bank
  import free_list_banked_pkg::*;
#(
  parameter bank_idx_t BANK_IDX = '0
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   push_valid,
  input  pr_t    push_pr,
  input  logic   pop_ready,
  output logic   alloc_valid,
  output pr_t    alloc_pr,
  output count_t count,
  output count_t count_next
);

  pr_entry_t mem_reg [FREE_LIST_LENGTH_PER_BANK];
  ptr_t      head_reg;
  ptr_t      tail_reg;
  count_t    count_reg;

  logic stored_valid;
  logic full;
  logic do_push;
  logic do_pop;

  assign stored_valid = (count_reg != '0);
  assign full         = (count_reg == count_t'(FREE_LIST_LENGTH_PER_BANK));
  assign count        = count_reg;

  always_comb begin
    alloc_valid = stored_valid;
    alloc_pr    = {mem_reg[head_reg], BANK_IDX};
    do_pop      = stored_valid && pop_ready;
`ifdef FREE_LIST_BYPASS_EN
    // Empty bank: forward the incoming PR; if it is taken at once, nothing is stored.
    if (!stored_valid && push_valid) begin
      alloc_valid = 1'b1;
      alloc_pr    = push_pr;
    end
    do_push = push_valid && !full && !(!stored_valid && pop_ready);
`else
    do_push = push_valid && !full;
`endif
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + count_t'(1);
    end else if (do_pop && !do_push) begin
      count_next = count_reg - count_t'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FREE_LIST_LENGTH_PER_BANK; i++) begin
        mem_reg[i] <= (i < INIT_COUNT_PER_BANK) ? init_entry(i) : '0;
      end
      head_reg  <= '0;
      tail_reg  <= ptr_t'(INIT_COUNT_PER_BANK);
      count_reg <= count_t'(INIT_COUNT_PER_BANK);
    end else begin
      if (push_valid) begin
        assert (!full) else $error("free_list_bank %0d: push into full bank dropped", BANK_IDX);
        assert (push_pr[LOG_FREE_LIST_BANK_COUNT-1:0] == BANK_IDX)
          else $error("free_list_bank %0d: PR %0d pushed to wrong bank", BANK_IDX, push_pr);
      end
      // The stored entry drops the bank bits; a mis-banked PR keeps only its upper bits.
      if (do_push) begin
        mem_reg[tail_reg] <= push_pr[LOG_PR_COUNT-1:LOG_FREE_LIST_BANK_COUNT];
        tail_reg          <= tail_reg + ptr_t'(1);
      end
      if (do_pop) begin
        head_reg <= head_reg + ptr_t'(1);
      end
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/free_list_banked.sv
// free_list_banked
// Banked physical-register free list between ROB commit and rename. Each bank
// holds the free PRs whose low bits equal its index; the top adds the
// aggregate stall flag with hysteresis.
//   CLK  clock
//   RST  asynchronous active-high reset
//   fl   free_list_banked_if.slave: dealloc/alloc handshakes, counts, stall
// Optional: FREE_LIST_BYPASS_EN (see free_list_bank) enables same-cycle
// presentation of a PR freed into an empty bank.
module free_list_banked
  import free_list_banked_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  free_list_banked_if.slave   fl
);

  count_t count_by_bank      [FREE_LIST_BANK_COUNT];
  count_t count_next_by_bank [FREE_LIST_BANK_COUNT];
  logic   any_low;
  logic   all_high;
  logic   stall_reg;
  logic   stall_next;

  generate
    for (genvar gi = 0; gi < FREE_LIST_BANK_COUNT; gi++) begin : g_bank
      pr_t  alloc_pr;
      logic alloc_valid;

      free_list_bank #(
        .BANK_IDX (bank_idx_t'(gi))
      ) u_bank (
        .CLK         (CLK),
        .RST         (RST),
        .push_valid  (fl.dealloc_valid_by_bank[gi]),
        .push_pr     (fl.dealloc_PR_by_bank[gi]),
        .pop_ready   (fl.alloc_ready_by_bank[gi]),
        .alloc_valid (alloc_valid),
        .alloc_pr    (alloc_pr),
        .count       (count_by_bank[gi]),
        .count_next  (count_next_by_bank[gi])
      );

      assign fl.alloc_valid_by_bank[gi] = alloc_valid;
      assign fl.alloc_PR_by_bank[gi]    = alloc_pr;
      assign fl.free_count_by_bank[gi]  = count_by_bank[gi];
    end
  endgenerate

  // Hysteresis on next counts: set below LOWER, clear only when all reach UPPER.
  always_comb begin
    any_low  = 1'b0;
    all_high = 1'b1;
    for (int b = 0; b < FREE_LIST_BANK_COUNT; b++) begin
      if (count_next_by_bank[b] < count_t'(FREE_LIST_LOWER_THRESHOLD)) begin
        any_low = 1'b1;
      end
      if (count_next_by_bank[b] < count_t'(FREE_LIST_UPPER_THRESHOLD)) begin
        all_high = 1'b0;
      end
    end
    stall_next = stall_reg;
    if (any_low) begin
      stall_next = 1'b1;
    end else if (all_high) begin
      stall_next = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_reg <= 1'b0;
    end else begin
      stall_reg <= stall_next;
    end
  end

  assign fl.free_list_stall = stall_reg;

endmodule

// File: tb/tb_free_list_banked.sv
// tb_free_list_banked
// Scoreboard bench for free_list_banked: every freed PR is queued per bank when
// driven and compared against alloc_PR when rename takes it; counts and stall
// come from a reference model of the queue sizes and the hysteresis rule.
module tb_free_list_banked;
  import free_list_banked_pkg::*;

  localparam int NB = FREE_LIST_BANK_COUNT;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  free_list_banked_if fl();

  free_list_banked dut (
    .CLK (clk),
    .RST (rst),
    .fl  (fl)
  );

  int checks   = 0;
  int failures = 0;
  int sb [NB][$];
  bit stall_m;
  int fill_k = 0;

  task automatic check_eq(input string tag, input int b, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s bank%0d got=%0d expected=%0d", tag, b, got, exp);
    end
  endtask

  task automatic reset_model();
    for (int b = 0; b < NB; b++) begin
      sb[b].delete();
      for (int i = 0; i < INIT_COUNT_PER_BANK; i++) sb[b].push_back(AR_COUNT + NB * i + b);
    end
    stall_m = 1'b0;
  endtask

  task automatic clear_inputs();
    fl.dealloc_valid_by_bank = '0;
    fl.dealloc_PR_by_bank    = '0;
    fl.alloc_ready_by_bank   = '0;
  endtask

  task automatic drive(input int b, input bit push, input int pr, input bit pop);
    fl.dealloc_valid_by_bank[b] = push;
    fl.dealloc_PR_by_bank[b]    = pr_t'(pr);
    fl.alloc_ready_by_bank[b]   = pop;
  endtask

  function automatic bit bypass_on();
`ifdef FREE_LIST_BYPASS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_comb();
    for (int b = 0; b < NB; b++) begin
      bit exp_v;
      exp_v = (sb[b].size() != 0) || (bypass_on() && fl.dealloc_valid_by_bank[b]);
      check_eq("alloc_valid", b, 32'(fl.alloc_valid_by_bank[b]), 32'(exp_v));
      if (exp_v)
        check_eq("alloc_pr", b, 32'(fl.alloc_PR_by_bank[b]),
                 (sb[b].size() != 0) ? 32'(sb[b][0]) : 32'(fl.dealloc_PR_by_bank[b]));
    end
  endtask

  task automatic check_regs();
    for (int b = 0; b < NB; b++)
      check_eq("free_count", b, 32'(fl.free_count_by_bank[b]), 32'(sb[b].size()));
    check_eq("stall", 0, 32'(fl.free_list_stall), 32'(stall_m));
  endtask

  // One clock: check presented outputs, advance the model, take the edge, check state.
  task automatic cycle();
    bit any_low, all_high;
    #1;
    check_comb();
    for (int b = 0; b < NB; b++) begin
      bit push, pop;
      push = fl.dealloc_valid_by_bank[b];
      pop  = fl.alloc_ready_by_bank[b];
      if (sb[b].size() == 0 && push && pop && bypass_on()) begin
        $display("alloc bank%0d pr=%0d (bypass)", b, fl.dealloc_PR_by_bank[b]);
      end else begin
        if (pop && sb[b].size() != 0) $display("alloc bank%0d pr=%0d", b, sb[b].pop_front());
        if (push) begin
          sb[b].push_back(int'(fl.dealloc_PR_by_bank[b]));
          $display("dealloc bank%0d pr=%0d", b, fl.dealloc_PR_by_bank[b]);
        end
      end
    end
    any_low = 1'b0; all_high = 1'b1;
    for (int b = 0; b < NB; b++) begin
      if (sb[b].size() < FREE_LIST_LOWER_THRESHOLD) any_low = 1'b1;
      if (sb[b].size() < FREE_LIST_UPPER_THRESHOLD) all_high = 1'b0;
    end
    if (any_low) stall_m = 1'b1;
    else if (all_high) stall_m = 1'b0;
    @(posedge clk);
    #1;
    clear_inputs();
    check_regs();
  endtask

  task automatic random_traffic(input int n);
    for (int c = 0; c < n; c++) begin
      for (int b = 0; b < NB; b++)
        drive(b, ($urandom_range(0, 1) == 1) && (sb[b].size() < 31),
              NB * $urandom_range(0, 31) + b, $urandom_range(0, 1) == 1);
      cycle();
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    reset_model();
    @(posedge clk);
    #1;
    check_comb();
    check_regs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Drain bank0 (plus one ignored take while empty); stall rises at count 7.
    for (int i = 0; i < 25; i++) begin drive(0, 1'b0, 0, 1'b1); cycle(); end

    // Free PR 4 into empty bank0, let it appear, then take it.
    drive(0, 1'b1, 4, 1'b0); cycle();
    cycle();
    drive(0, 1'b0, 0, 1'b1); cycle();

    // Bank2: down to 10, wrap tail past 31, back to 10, then push+pop together.
    for (int i = 0; i < 14; i++) begin drive(2, 1'b0, 0, 1'b1); cycle(); end
    for (int i = 0; i < 8; i++)  begin drive(2, 1'b1, 34 + 4 * i, 1'b0); cycle(); end
    for (int i = 0; i < 8; i++)  begin drive(2, 1'b0, 0, 1'b1); cycle(); end
    drive(2, 1'b1, 6, 1'b1); cycle();
    for (int i = 0; i < 11; i++) begin drive(2, 1'b0, 0, 1'b1); cycle(); end

    // Stall hysteresis: trim banks to <=20, refill all to 23, then one more each.
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b0, 0, 1'b1); drive(3, 1'b0, 0, 1'b1); cycle();
    end
    for (int n = 0; n < 40; n++) begin
      bit all23;
      all23 = 1'b1;
      for (int b = 0; b < NB; b++) if (sb[b].size() < 23) all23 = 1'b0;
      if (all23) break;
      for (int b = 0; b < NB; b++)
        if (sb[b].size() < 23) begin
          drive(b, 1'b1, NB * (8 + (fill_k % 24)) + b, 1'b0);
          fill_k++;
        end
      cycle();
    end
    for (int b = 0; b < NB; b++) check_eq("refill23", b, 32'(fl.free_count_by_bank[b]), 32'd23);
    check_eq("stall_hold", 0, 32'(fl.free_list_stall), 32'd1);
    for (int b = 0; b < NB; b++) drive(b, 1'b1, NB * 30 + b, 1'b0);
    cycle();
    check_eq("stall_clear", 0, 32'(fl.free_list_stall), 32'd0);

    // Random traffic, then an asynchronous reset between edges.
    random_traffic(40);
    for (int b = 0; b < NB; b++) drive(b, 1'b1, NB * 5 + b, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    reset_model();
    check_comb();
    check_regs();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_regs();
    random_traffic(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bank0 got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
